// File: rtl/add64_sequencer_if.sv
// Request/response bundle for the 64-bit slice-sequenced adder.
// The master issues start with operands; the slave reports ready, done
// and the registered result with its carry and overflow flags.
interface add64_sequencer_if;
  logic        start;
  logic        sub;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic        ready;
  logic        done;
  logic [63:0] result;
  logic        cout;
  logic        overflow;

  modport master (
    output start,
    output sub,
    output op_a,
    output op_b,
    input  ready,
    input  done,
    input  result,
    input  cout,
    input  overflow
  );

  modport slave (
    input  start,
    input  sub,
    input  op_a,
    input  op_b,
    output ready,
    output done,
    output result,
    output cout,
    output overflow
  );
endinterface

// File: rtl/add64_sequencer.sv
// 64-bit add/subtract built from a single 16-bit carry-lookahead adder that
// is reused over four clock cycles, least significant slice first.
// Subtraction is done as A + ~B + 1: B is inverted at capture time and the
// slice-0 carry-in is seeded with the sub flag.

// 16-bit adder: four 4-bit lookahead groups joined by a second-level
// lookahead unit. g is the carry out of bit 15.
module adder_16_bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        g
);

  logic [15:0] bit_p;
  logic [15:0] bit_g;
  logic [3:0]  grp_p;
  logic [3:0]  grp_g;
  logic [4:0]  grp_c;
  logic [15:0] bit_c;

  // Carries into each bit of a 4-bit group from its propagate/generate terms.
  function automatic logic [3:0] cla4(input logic [3:0] p, input logic [3:0] gn, input logic c0);
    logic [3:0] c;
    c[0] = c0;
    c[1] = gn[0] | (p[0] & c0);
    c[2] = gn[1] | (p[1] & gn[0]) | (p[1] & p[0] & c0);
    c[3] = gn[2] | (p[2] & gn[1]) | (p[2] & p[1] & gn[0]) | (p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  // Per-bit propagate/generate and per-group summary terms.
  always_comb begin
    bit_p = a ^ b;
    bit_g = a & b;
    for (int i = 0; i < 4; i++) begin
      grp_p[i] = &bit_p[4*i +: 4];
      grp_g[i] = bit_g[4*i+3]
               | (bit_p[4*i+3] & bit_g[4*i+2])
               | (bit_p[4*i+3] & bit_p[4*i+2] & bit_g[4*i+1])
               | (bit_p[4*i+3] & bit_p[4*i+2] & bit_p[4*i+1] & bit_g[4*i]);
    end
  end

  // Second-level lookahead producing the carry into each group and out of the top.
  always_comb begin
    grp_c[0] = cin;
    grp_c[1] = grp_g[0] | (grp_p[0] & cin);
    grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);
    grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[2] & grp_p[1] & grp_p[0] & cin);
    grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin);
  end

  // Bit-level carries inside each group, then the sum bits.
  always_comb begin
    bit_c = '0;
    for (int i = 0; i < 4; i++) begin
      bit_c[4*i +: 4] = cla4(bit_p[4*i +: 4], bit_g[4*i +: 4], grp_c[i]);
    end
    sum = bit_p ^ bit_c;
    g   = grp_c[4];
  end

endmodule

// Sequencer: captures operands on an accepted start, walks the shared adder
// across the four slices, then presents the result for one done cycle.
module add64_sequencer (
  input  logic             clk,
  input  logic             rst,
  add64_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  slice_cnt;
  logic        carry_q;
  logic [63:0] opa_q;
  logic [63:0] opb_q;
  logic        sign_a_q;
  logic        sign_b_q;
  logic [63:0] result_q;
  logic        cout_q;
  logic        overflow_q;
  logic        accept;
  logic        last_slice;
  logic [15:0] slice_a;
  logic [15:0] slice_b;
  logic [15:0] slice_sum;
  logic        slice_g;

  // State register; reset drops straight back to IDLE, aborting any operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus the accept and last-slice strobes used by the datapath.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_slice = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (slice_cnt == 2'd3) begin
          last_slice = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Selects the current slice of both captured operands for the shared adder.
  always_comb begin
    slice_a = opa_q[15:0];
    slice_b = opb_q[15:0];
    case (slice_cnt)
      2'd0: begin
        slice_a = opa_q[15:0];
        slice_b = opb_q[15:0];
      end
      2'd1: begin
        slice_a = opa_q[31:16];
        slice_b = opb_q[31:16];
      end
      2'd2: begin
        slice_a = opa_q[47:32];
        slice_b = opb_q[47:32];
      end
      default: begin
        slice_a = opa_q[63:48];
        slice_b = opb_q[63:48];
      end
    endcase
  end

  adder_16_bit u_adder (
    .a   (slice_a),
    .b   (slice_b),
    .cin (carry_q),
    .sum (slice_sum),
    .g   (slice_g)
  );

  // Datapath: operand capture on accept, one slice written per RUN cycle,
  // flags latched alongside the top slice and held until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slice_cnt  <= 2'd0;
      carry_q    <= 1'b0;
      opa_q      <= '0;
      opb_q      <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else if (accept) begin
      opa_q     <= bus.op_a;
      opb_q     <= bus.op_b ^ {64{bus.sub}};
      carry_q   <= bus.sub;
      sign_a_q  <= bus.op_a[63];
      sign_b_q  <= bus.op_b[63] ^ bus.sub;
      slice_cnt <= 2'd0;
    end else if (state == RUN) begin
      case (slice_cnt)
        2'd0:    result_q[15:0]  <= slice_sum;
        2'd1:    result_q[31:16] <= slice_sum;
        2'd2:    result_q[47:32] <= slice_sum;
        default: result_q[63:48] <= slice_sum;
      endcase
      carry_q   <= slice_g;
      slice_cnt <= slice_cnt + 2'd1;
      if (last_slice) begin
        cout_q     <= slice_g;
        overflow_q <= (sign_a_q == sign_b_q) && (slice_sum[15] != sign_a_q);
      end
    end
  end

  assign bus.ready    = (state != RUN);
  assign bus.done     = (state == DONE);
  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_add64_sequencer.sv
// Directed bench for add64_sequencer: a table of hand-computed vectors plus
// sequences for back-to-back issue, start during RUN and reset mid-operation.
module tb_add64_sequencer;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  add64_sequencer_if bus();

  add64_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic [63:0] exp_result;
    logic        exp_cout;
    logic        exp_ovf;
  } vector_t;

  vector_t vecs [9];

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Presents an operation, holds start across one edge, then scrambles the
  // operand inputs so any late sampling would corrupt the result.
  task automatic apply_stimulus(input logic [63:0] a, input logic [63:0] b, input logic s);
    bus.op_a  = a;
    bus.op_b  = b;
    bus.sub   = s;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op_a  = ~a;
    bus.op_b  = ~b ^ 64'h5A5A_5A5A_5A5A_5A5A;
    bus.sub   = ~s;
  endtask

  // Waits for done with a bounded cycle budget; returns edges counted.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < 12) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic do_op(input string name, input logic [63:0] a, input logic [63:0] b, input logic s);
    int cyc;
    apply_stimulus(a, b, s);
    check_output({name, " ready_in_run"}, {63'd0, bus.ready}, 64'd0);
    wait_done(cyc);
    check_output({name, " latency"}, cyc, 64'd4);
  endtask

  task automatic verify(input string name, input logic [63:0] er, input logic ec, input logic eo);
    check_output({name, " done"},     {63'd0, bus.done},     64'd1);
    check_output({name, " ready"},    {63'd0, bus.ready},    64'd1);
    check_output({name, " result"},   bus.result,            er);
    check_output({name, " cout"},     {63'd0, bus.cout},     {63'd0, ec});
    check_output({name, " overflow"}, {63'd0, bus.overflow}, {63'd0, eo});
  endtask

  initial begin
    int  cyc;
    bit  saw_done;
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;

    vecs[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[3] = '{64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
    vecs[5] = '{64'h7, 64'h5, 1'b1, 64'h2, 1'b1, 1'b0};
    vecs[6] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[7] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 64'h2222_2222_2222_2211, 1'b0, 1'b0};
    vecs[8] = '{64'h0, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};

    #12;
    check_output("reset result",   bus.result,            64'd0);
    check_output("reset cout",     {63'd0, bus.cout},     64'd0);
    check_output("reset overflow", {63'd0, bus.overflow}, 64'd0);
    check_output("reset done",     {63'd0, bus.done},     64'd0);
    check_output("reset ready",    {63'd0, bus.ready},    64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      do_op(nm, vecs[i].a, vecs[i].b, vecs[i].sub);
      verify(nm, vecs[i].exp_result, vecs[i].exp_cout, vecs[i].exp_ovf);
      @(posedge clk);
      #1;
      check_output({nm, " done_pulse"}, {63'd0, bus.done}, 64'd0);
      @(posedge clk);
      #1;
      check_output({nm, " hold_result"},   bus.result,            vecs[i].exp_result);
      check_output({nm, " hold_overflow"}, {63'd0, bus.overflow}, {63'd0, vecs[i].exp_ovf});
    end

    // Back-to-back: the next start is presented in the DONE cycle itself.
    do_op("b2b first", 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0);
    verify("b2b first", 64'h0000_0001_0000_0000, 1'b0, 1'b0);
    do_op("b2b second", 64'h10, 64'h3, 1'b1);
    verify("b2b second", 64'hD, 1'b1, 1'b0);
    @(posedge clk);
    #1;

    // Start and operand changes while RUN must be ignored.
    apply_stimulus(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0);
    bus.start = 1'b1;
    bus.op_a  = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.op_b  = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.sub   = 1'b1;
    @(posedge clk);
    #1;
    check_output("runstart ready1", {63'd0, bus.ready}, 64'd0);
    @(posedge clk);
    #1;
    check_output("runstart ready2", {63'd0, bus.ready}, 64'd0);
    bus.start = 1'b0;
    wait_done(cyc);
    check_output("runstart latency", cyc, 64'd2);
    verify("runstart", 64'h3333_3333_3333_3333, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // Reset pulsed while slice 2 is pending: immediate clear, no done.
    apply_stimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_output("midrst result",   bus.result,            64'd0);
    check_output("midrst cout",     {63'd0, bus.cout},     64'd0);
    check_output("midrst overflow", {63'd0, bus.overflow}, 64'd0);
    check_output("midrst done",     {63'd0, bus.done},     64'd0);
    check_output("midrst ready",    {63'd0, bus.ready},    64'd1);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    check_output("midrst no_done", {63'd0, saw_done}, 64'd0);
    do_op("post_rst", 64'h1, 64'h2, 1'b0);
    verify("post_rst", 64'h3, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/add64_sequencer.md
ADD64_SEQUENCER -- requirements
Module: add64_sequencer

Interface
REQ-001 The block SHALL have no parameters; the operand width is fixed at 64 bits and the slice width at 16 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request; accepted only on a rising edge where ready=1.
REQ-005 sub  input  1  0 = A+B, 1 = A-B; sampled with start.
REQ-006 op_a  input  64  operand A; sampled with start.
REQ-007 op_b  input  64  operand B; sampled with start.
REQ-008 ready  output  1  block can accept start.
REQ-009 done  output  1  one-cycle pulse; result, cout and overflow are valid.
REQ-010 result  output  64  sum or difference, registered.
REQ-011 cout  output  1  carry out of bit 63 (for sub: 1 = no borrow).
REQ-012 overflow  output  1  two's-complement signed overflow of the 64-bit operation.

Function
REQ-013 The block SHALL instantiate exactly one adder_16_bit and time-share it over four slices, least significant first.
REQ-014 The FSM SHALL have states IDLE, RUN and DONE; the slice counter SHALL be 2 bits (0..3).
REQ-015 IDLE/DONE with start=1 -> RUN:
- capture op_a
- capture op_b XOR {64{sub}}
- carry register <= sub
- capture sign bits op_a[63] and op_b[63]^sub
- slice counter <= 0
REQ-016 IDLE/DONE with start=0:
- DONE -> IDLE
- IDLE stays IDLE
REQ-017 RUN, each cycle:
- apply slice k = counter of both captured operands to the adder, with cin = carry register
- write the adder sum into result[16k+15:16k]
- carry register <= the adder G output
- increment the counter
REQ-018 RUN with counter=3 SHALL go to DONE on the same edge that writes the top slice.
REQ-019 ready SHALL be 1 in IDLE and DONE and 0 in RUN; start in RUN SHALL be ignored without side effects.
REQ-020 Latency:
- start sampled at edge t0
- slices written at edges t0+1..t0+4
- done=1 for the cycle following edge t0+4
- earliest back-to-back start at edge t0+5, giving a throughput of one operation per 5 cycles
REQ-021 done SHALL be 1 only in DONE and SHALL last exactly one cycle.
REQ-022 cout SHALL equal the carry register value after the slice-3 edge.
REQ-023 overflow SHALL be 1 iff the two captured sign bits are equal and result[63] differs from them; it SHALL be evaluated after slice 3.
REQ-024 result, cout and overflow SHALL hold their values from DONE until the next accepted start.
REQ-025 During RUN, result SHALL contain partial data that is not valid.
REQ-026 Changes on op_a, op_b and sub after the start edge SHALL NOT affect the operation in flight.
REQ-027 Arithmetic SHALL wrap modulo 2^64; no saturation.

Reset
REQ-028 rst=1 SHALL immediately, independent of clk, set:
- state = IDLE
- counter = 0
- carry register = 0
- result = 0
- cout = 0
- overflow = 0
- done = 0
- ready = 1
REQ-029 rst asserted during RUN SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL behave as a fresh operation.

Verification
REQ-030 The bench SHALL cover the carry ripple: A=0x0000_0000_0000_FFFF, B=1, sub=0 -> done 5 cycles after start, result=0x0000_0000_0001_0000, cout=0, overflow=0.
REQ-031 The bench SHALL cover full carry-out: A=0xFFFF_FFFF_FFFF_FFFF, B=1, sub=0 -> result=0, cout=1, overflow=0.
REQ-032 The bench SHALL cover signed overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=1, sub=0 -> result=0x8000_0000_0000_0000, overflow=1, cout=0.
REQ-033 The bench SHALL cover subtract with borrow: A=5, B=7, sub=1 -> result=0xFFFF_FFFF_FFFF_FFFE, cout=0, overflow=0.
REQ-034 The bench SHALL cover start in RUN and operand changes: start pulsed and op_a/op_b changed during RUN -> ignored, ready=0, and the original result is delivered.
REQ-035 The bench SHALL cover reset mid-operation: rst pulsed at slice 2 -> all outputs 0, ready=1, no done; the next operation A=1, B=2 gives result=3.
